conv_stream_feeder: RTL

//  Producer end of the convolver pixel-shift interface. Accepts a raster-order feature-map stream

---
 rtl/conv_stream_feeder_pkg.sv | 19 +
 rtl/conv_stream_feeder_raster_pos_counter.sv | 49 ++++
 rtl/conv_stream_feeder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/conv_stream_feeder_pkg.sv
// Shared constants, state encoding and helpers for the convolver pixel-shift feeder.
package conv_stream_feeder_pkg;

  localparam int WID_FIFO  = 16;
  localparam int DIM_W_DEF = 8;
  localparam int WIN_K     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } feeder_state_e;

  // A frame smaller than the window in either direction can never produce a window.
  function automatic logic dims_ok(input int unsigned w, input int unsigned h);
    return (w >= WIN_K) && (h >= WIN_K);
  endfunction

endpackage

// File: rtl/conv_stream_feeder_raster_pos_counter.sv
// Raster-order column/row position counter with synchronous clear and advance enable.
module raster_pos_counter #(
  parameter int DIM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [DIM_W-1:0] width_i,
  output logic [DIM_W-1:0] col_o,
  output logic [DIM_W-1:0] row_o,
  output logic             last_col_o
);

  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] row_q, row_d;

  assign last_col_o = (col_q == width_i - DIM_W'(1));
  assign col_o      = col_q;
  assign row_o      = row_q;

  // Clear takes priority so a new frame always starts at (0,0).
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (last_col_o) begin
        col_d = '0;
        row_d = row_q + DIM_W'(1);
      end else begin
        col_d = col_q + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/conv_stream_feeder.sv
// Producer end of the convolver shift interface: re-times accepted pixels onto the
// shift chain with a one-cycle strobe and flags pixels that complete a 3x3 window.
module conv_stream_feeder
  import conv_stream_feeder_pkg::*;
#(
  parameter int WID   = WID_FIFO,
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DIM_W-1:0] img_w_i,
  input  logic [DIM_W-1:0] img_h_i,
  input  logic             stall_i,
  input  logic             in_valid_i,
  input  logic [WID-1:0]   in_data_i,
  output logic             in_ready_o,
  output logic [WID-1:0]   sr_data_o,
  output logic             shifting_o,
  output logic             win_valid_o,
  output logic [DIM_W-1:0] row_cnt_o,
  output logic [DIM_W-1:0] col_cnt_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [DIM_W-1:0] WinMin = DIM_W'(WIN_K - 1);

  feeder_state_e    state_q, state_d;
  logic [DIM_W-1:0] img_w_q, img_w_d;
  logic [DIM_W-1:0] img_h_q, img_h_d;
  logic [WID-1:0]   sr_data_q, sr_data_d;
  logic [DIM_W-1:0] row_cnt_q, row_cnt_d;
  logic [DIM_W-1:0] col_cnt_q, col_cnt_d;
  logic             shifting_q, shifting_d;
  logic             win_valid_q, win_valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             accept;
  logic             start_idle;
  logic             start_good;
  logic             last_pix;
  logic [DIM_W-1:0] pos_col;
  logic [DIM_W-1:0] pos_row;
  logic             pos_last_col;

  assign accept     = in_valid_i && in_ready_o;
  assign start_idle = (state_q == ST_IDLE) && start_i;
  assign start_good = dims_ok(32'(img_w_i), 32'(img_h_i));
  assign last_pix   = pos_last_col && (pos_row == img_h_q - DIM_W'(1));

  raster_pos_counter #(
    .DIM_W(DIM_W)
  ) u_pos (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (start_idle),
    .en_i      (accept),
    .width_i   (img_w_q),
    .col_o     (pos_col),
    .row_o     (pos_row),
    .last_col_o(pos_last_col)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_i && start_good) state_d = ST_RUN;
      ST_RUN:  if (accept && last_pix) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o = (state_q == ST_RUN) && !stall_i;
    busy_o     = (state_q == ST_RUN);
  end

  // Position, data and window flag are captured together so they stay aligned with the strobe.
  always_comb begin
    img_w_d     = img_w_q;
    img_h_d     = img_h_q;
    sr_data_d   = sr_data_q;
    row_cnt_d   = row_cnt_q;
    col_cnt_d   = col_cnt_q;
    shifting_d  = accept;
    win_valid_d = accept && (pos_row >= WinMin) && (pos_col >= WinMin);
    done_d      = (state_q == ST_DONE);
    err_d       = start_idle && !start_good;
    if (start_idle) begin
      img_w_d = img_w_i;
      img_h_d = img_h_i;
    end
    if (accept) begin
      sr_data_d = in_data_i;
      row_cnt_d = pos_row;
      col_cnt_d = pos_col;
    end
  end

  // done is registered off DONE so it lands after the final pixel's shift cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_w_q     <= '0;
      img_h_q     <= '0;
      sr_data_q   <= '0;
      row_cnt_q   <= '0;
      col_cnt_q   <= '0;
      shifting_q  <= 1'b0;
      win_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      img_w_q     <= img_w_d;
      img_h_q     <= img_h_d;
      sr_data_q   <= sr_data_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      shifting_q  <= shifting_d;
      win_valid_q <= win_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign sr_data_o   = sr_data_q;
  assign row_cnt_o   = row_cnt_q;
  assign col_cnt_o   = col_cnt_q;
  assign shifting_o  = shifting_q;
  assign win_valid_o = win_valid_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
